// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: clocked, restartable register-bus stimulus sequencer.
// Sweeps addresses 0..NUM_REGS-1 with write and/or read beats. The mode is
// chosen at start. It also generates a response counter, periodic
// command_complete pulses and the interrupt status vectors. Every output is
// registered, so a beat decided in one cycle is seen on the bus after the
// next rising edge.
// Optional feature macro: REG_BUS_SEQ_CHECK_EN adds read-back checking
// (rd_data_i, mismatch_count). In modes 2/3 the read-back data for a read beat
// must be on rd_data_i during the cycle after reg_read_en/adr_o are high.
// That is the cycle in which it is sampled and compared.
module reg_bus_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 128,
  parameter int NUM_REGS   = 16,
  parameter int DATA_STEP  = 2,
  parameter int CMD_PERIOD = 8,
  parameter int IRQ_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] adr_o,
  output logic              reg_write_en,
  output logic              reg_read_en,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] response_o,
  output logic              command_complete,
  output logic [IRQ_W-1:0]  normal_interrupt_status_o,
  output logic [IRQ_W-1:0]  error_interrupt_status_o,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_count
`ifdef REG_BUS_SEQ_CHECK_EN
  ,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [15:0]       mismatch_count
`endif
);

  localparam int                CNT_W       = (CMD_PERIOD > 1) ? $clog2(CMD_PERIOD) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(CMD_PERIOD - 1);
  localparam logic [DATA_W-1:0] PASS_STRIDE = DATA_W'(NUM_REGS * DATA_STEP);
  localparam logic [DATA_W-1:0] IDX_STRIDE  = DATA_W'(DATA_STEP);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;
  typedef enum logic [1:0] {M_WRITE = 2'd0, M_READ = 2'd1, M_WR_RD = 2'd2, M_CONT = 2'd3} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              stop_q, stop_d;
  logic [15:0]       pass_q, pass_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              wrap_q, wrap_d;
  logic              cc_q, cc_d;
  logic              irq_cc_q, irq_cc_d;
  logic              irq_done_q, irq_done_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_sweep;
  logic              beat;
  logic              last_idx;
  logic [DATA_W-1:0] wr_data;

  assign in_sweep = (state_q == S_WRITE) || (state_q == S_READ);
  assign beat     = in_sweep && !pause;
  assign last_idx = (idx_q == LAST_IDX);
  // Write data is linear in the global beat position: one pass spans NUM_REGS steps.
  assign wr_data  = DATA_W'(pass_q) * PASS_STRIDE + DATA_W'(idx_q) * IDX_STRIDE;

  // Next-state, beat generation and registered-output values.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can leave a latch behind.
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    stop_d     = stop_q;
    pass_d     = pass_q;
    adr_d      = adr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    wrap_d     = 1'b0;
    cc_d       = wrap_q;
    irq_cc_d   = cc_q;
    busy_d     = in_sweep;
    done_d     = (state_q == S_DONE);
    irq_done_d = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode_e'(mode);
          pass_d     = '0;
          resp_d     = '0;
          beat_cnt_d = '0;
          stop_d     = 1'b0;
          idx_d      = '0;
          state_d    = (mode_e'(mode) == M_READ) ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (!pause) begin
          wr_en_d = 1'b1;
          adr_d   = idx_q;
          data_d  = wr_data;
          if (last_idx) begin
            idx_d   = '0;
            state_d = (mode_q == M_WRITE) ? S_DONE : S_READ;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_READ: begin
        if (!pause) begin
          rd_en_d = 1'b1;
          adr_d   = idx_q;
          resp_d  = resp_q + DATA_W'(1);
          if (last_idx) begin
            idx_d = '0;
            // A stop raised in this very cycle still ends the sequence here.
            if (mode_q == M_CONT && !(stop_q || stop)) begin
              state_d = S_WRITE;
              pass_d  = pass_q + 16'd1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_sweep && mode_q == M_CONT && stop) stop_d = 1'b1;

    if (beat) begin
      if (beat_cnt_q == LAST_CNT) begin
        beat_cnt_d = '0;
        wrap_d     = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here, so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= M_WRITE;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      stop_q     <= 1'b0;
      pass_q     <= '0;
      adr_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      data_q     <= '0;
      resp_q     <= '0;
      wrap_q     <= 1'b0;
      cc_q       <= 1'b0;
      irq_cc_q   <= 1'b0;
      irq_done_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      stop_q     <= stop_d;
      pass_q     <= pass_d;
      adr_q      <= adr_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      wrap_q     <= wrap_d;
      cc_q       <= cc_d;
      irq_cc_q   <= irq_cc_d;
      irq_done_q <= irq_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign adr_o            = adr_q;
  assign reg_write_en     = wr_en_q;
  assign reg_read_en      = rd_en_q;
  assign data_o           = data_q;
  assign response_o       = resp_q;
  assign command_complete = cc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_count       = pass_q;

  // Normal interrupt vector: bit 0 trails command_complete, bit 1 marks done.
  always_comb begin
    normal_interrupt_status_o    = '0;
    normal_interrupt_status_o[0] = irq_cc_q;
    normal_interrupt_status_o[1] = irq_done_q;
  end

`ifdef REG_BUS_SEQ_CHECK_EN
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;
  logic              chk_vld_q, chk_vld_d;
  logic [15:0]       mism_q, mism_d;
  logic              err_q, err_d;

  // Read-back compare pipeline. The expected value is captured with the read beat,
  // and the compare happens in the cycle after the beat is on the bus.
  always_comb begin
    exp_d     = (state_q == S_READ && !pause) ? wr_data : exp_q;
    chk_vld_d = rd_en_q && (mode_q == M_WR_RD || mode_q == M_CONT);
    chk_exp_d = exp_q;
    mism_d    = mism_q;
    err_d     = err_q;
    if (chk_vld_q && (rd_data_i != chk_exp_q)) begin
      if (mism_q != 16'hFFFF) mism_d = mism_q + 16'd1;
      err_d = 1'b1;
    end
    if (state_q == S_IDLE && start) begin
      mism_d = '0;
      err_d  = 1'b0;
    end
  end

  // Check-pipeline registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_q     <= '0;
      chk_exp_q <= '0;
      chk_vld_q <= 1'b0;
      mism_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      chk_exp_q <= chk_exp_d;
      chk_vld_q <= chk_vld_d;
      mism_q    <= mism_d;
      err_q     <= err_d;
    end
  end

  assign mismatch_count = mism_q;

  // Error interrupt vector: bit 0 is the sticky mismatch flag.
  always_comb begin
    error_interrupt_status_o    = '0;
    error_interrupt_status_o[0] = err_q;
  end
`else
  assign error_interrupt_status_o = '0;
`endif

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: directed stimulus for reg_bus_sequencer.
// A beat-index model (beat k -> phase, address, data) predicts every output
// on every cycle, and literal expectations pin the model in each scenario.
// Build with REG_BUS_SEQ_CHECK_EN to also cover read-back checking.
module tb_reg_bus_sequencer;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 128;
  localparam int NUM_REGS   = 16;
  localparam int DATA_STEP  = 2;
  localparam int CMD_PERIOD = 8;
  localparam int IRQ_W      = 16;
  localparam int FOREVER    = 1 << 30;

  logic              clock = 1'b0;
  logic              reset, start, pause, stop;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] adr_o;
  logic              reg_write_en, reg_read_en, command_complete, busy, done;
  logic [DATA_W-1:0] data_o, response_o;
  logic [IRQ_W-1:0]  normal_interrupt_status_o, error_interrupt_status_o;
  logic [15:0]       pass_count;
`ifdef REG_BUS_SEQ_CHECK_EN
  logic [DATA_W-1:0] rd_data_i = '0;
  logic [15:0]       mismatch_count;
`endif

  always #5 clock = ~clock;

  reg_bus_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .DATA_STEP(DATA_STEP), .CMD_PERIOD(CMD_PERIOD), .IRQ_W(IRQ_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .pause(pause), .stop(stop),
    .adr_o(adr_o), .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
    .data_o(data_o), .response_o(response_o), .command_complete(command_complete),
    .normal_interrupt_status_o(normal_interrupt_status_o),
    .error_interrupt_status_o(error_interrupt_status_o),
    .busy(busy), .done(done), .pass_count(pass_count)
`ifdef REG_BUS_SEQ_CHECK_EN
    , .rd_data_i(rd_data_i), .mismatch_count(mismatch_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              m_run = 1'b0, m_fin = 1'b0, m_wrap = 1'b0;
  int                m_k = 0, m_total = 0, m_phase = 0, m_idx = 0, m_pass = 0;
  logic [1:0]        m_mode = 2'd0;
  logic              m_is_wr;
  logic [ADDR_W-1:0] e_adr;
  logic              e_we, e_re, e_cc, e_irq0, e_irq1, e_busy, e_done;
  logic [DATA_W-1:0] e_data, e_resp;
  logic [15:0]       e_pass;

  always @(posedge clock) begin
    if (reset) begin
      m_run = 1'b0; m_fin = 1'b0; m_wrap = 1'b0; m_k = 0;
      e_adr = '0; e_we = 1'b0; e_re = 1'b0; e_data = '0; e_resp = '0;
      e_cc = 1'b0; e_irq0 = 1'b0; e_irq1 = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pass = '0;
    end else begin
      e_irq0 = e_cc;
      e_cc   = m_wrap;
      m_wrap = 1'b0;
      e_busy = m_run;
      e_done = m_fin;
      e_irq1 = m_fin;
      e_we   = 1'b0;
      e_re   = 1'b0;
      if (m_fin) begin
        m_fin = 1'b0;
      end else if (m_run) begin
        m_phase = m_k / NUM_REGS;
        // stop ends the sequence at the close of the current (or next) read phase
        if (stop && m_mode == 2'd3 && m_total == FOREVER)
          m_total = ((m_phase % 2 == 1) ? m_phase + 1 : m_phase + 2) * NUM_REGS;
        if (!pause) begin
          m_idx = m_k % NUM_REGS;
          case (m_mode)
            2'd0:    m_is_wr = 1'b1;
            2'd1:    m_is_wr = 1'b0;
            2'd2:    m_is_wr = (m_phase == 0);
            default: m_is_wr = (m_phase % 2 == 0);
          endcase
          m_pass = (m_mode == 2'd3) ? m_phase / 2 : 0;
          e_adr  = ADDR_W'(m_idx);
          if (m_is_wr) begin
            e_we   = 1'b1;
            e_data = DATA_W'(m_pass * NUM_REGS * DATA_STEP + m_idx * DATA_STEP);
          end else begin
            e_re   = 1'b1;
            e_resp = e_resp + 1;
          end
          m_k++;
          if (m_k % CMD_PERIOD == 0) m_wrap = 1'b1;
          if (m_k == m_total) begin
            m_run = 1'b0;
            m_fin = 1'b1;
          end else if (m_mode == 2'd3 && m_k % (2 * NUM_REGS) == 0) begin
            e_pass = 16'(m_k / (2 * NUM_REGS));
          end
        end
      end else if (start) begin
        m_mode = mode;
        m_run  = 1'b1;
        m_k    = 0;
        e_pass = '0;
        e_resp = '0;
        case (mode)
          2'd0, 2'd1: m_total = NUM_REGS;
          2'd2:       m_total = 2 * NUM_REGS;
          default:    m_total = FOREVER;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;
  int   obs_wr = 0, obs_rd = 0, obs_cc = 0;

  always @(negedge clock) begin
    if (cmp_en) begin
      check("adr_o", adr_o, e_adr);
      check("reg_write_en", reg_write_en, e_we);
      check("reg_read_en", reg_read_en, e_re);
      check("data_o", data_o, e_data);
      check("response_o", response_o, e_resp);
      check("command_complete", command_complete, e_cc);
      check("normal_irq", normal_interrupt_status_o, IRQ_W'({e_irq1, e_irq0}));
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pass_count", pass_count, e_pass);
      check("strobe_exclusive", reg_write_en & reg_read_en, 1'b0);
`ifndef REG_BUS_SEQ_CHECK_EN
      check("error_irq", error_interrupt_status_o, '0);
`endif
      if (reg_write_en) obs_wr++;
      if (reg_read_en) obs_rd++;
      if (command_complete) obs_cc++;
    end
  end

`ifdef REG_BUS_SEQ_CHECK_EN
  // Register-bank stand-in: stores writes and returns read data the cycle after a read beat.
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              pend_v = 1'b0;
  logic [ADDR_W-1:0] pend_a = '0;
  logic              corrupt = 1'b0;

  always @(negedge clock) begin
    if (pend_v) rd_data_i = mem[pend_a] ^ DATA_W'(corrupt && pend_a == ADDR_W'(3));
    else rd_data_i = '0;
    pend_v = reg_read_en;
    pend_a = adr_o;
    if (reg_write_en) mem[adr_o] = data_o;
  end
`endif

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic begin_seq(input logic [1:0] m);
    obs_wr = 0; obs_rd = 0; obs_cc = 0;
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; mode = 2'd0;
    step(2);
    cmp_en = 1'b1;
    check("reset adr_o", adr_o, 0);
    check("reset data_o", data_o, 0);
    check("reset busy", busy, 0);
    check("reset pass_count", pass_count, 0);
    check("reset normal_irq", normal_interrupt_status_o, 0);
    reset = 1'b0;
    step();

    // Mode 0: 16 writes, data 0..30, two command_complete pulses.
    begin_seq(2'd0);
    check("m0 latency no beat yet", reg_write_en, 0);
    step();
    check("m0 first beat strobe", reg_write_en, 1);
    check("m0 first beat adr", adr_o, 0);
    wait_done("m0 done");
    check("m0 write beats", obs_wr, 16);
    check("m0 read beats", obs_rd, 0);
    check("m0 cmd_complete pulses", obs_cc, 2);
    check("m0 last adr", adr_o, 15);
    check("m0 last data", data_o, 30);
    step(2);

    // Mode 1: 16 reads, response_o ends at 16.
    begin_seq(2'd1);
    wait_done("m1 done");
    check("m1 read beats", obs_rd, 16);
    check("m1 write beats", obs_wr, 0);
    check("m1 response_o", response_o, 16);
    step(2);

    // Pause 3 cycles after write beat idx 5.
    begin_seq(2'd0);
    n = 0;
    while (!(reg_write_en && adr_o == 5) && n < 50) begin step(); n++; end
    check("pause reached idx5", adr_o, 5);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause no write", reg_write_en, 0);
      check("pause adr hold", adr_o, 5);
      check("pause data hold", data_o, 10);
    end
    pause = 1'b0;
    step();
    check("pause resume strobe", reg_write_en, 1);
    check("pause resume adr", adr_o, 6);
    wait_done("pause done");
    check("pause write beats", obs_wr, 16);
    step(2);

    // Mode 3, stop during the second pass write sweep.
    begin_seq(2'd3);
    n = 0;
    while (!(reg_write_en && pass_count == 1) && n < 100) begin step(); n++; end
    check("m3 pass2 first adr", adr_o, 0);
    check("m3 pass2 first data", data_o, 32);
    step(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done("m3 done");
    check("m3 pass_count", pass_count, 1);
    check("m3 last write data", data_o, 62);
    check("m3 response_o", response_o, 32);
    check("m3 write beats", obs_wr, 32);
    check("m3 read beats", obs_rd, 32);
    check("m3 cmd_complete pulses", obs_cc, 8);
`ifdef REG_BUS_SEQ_CHECK_EN
    check("m3 no mismatch", mismatch_count, 0);
`endif
    step(2);

    // Reset at read idx 9, then restart from address 0.
    begin_seq(2'd1);
    n = 0;
    while (!(reg_read_en && adr_o == 9) && n < 50) begin step(); n++; end
    check("rst reached idx9", adr_o, 9);
    reset = 1'b1;
    step();
    check("rst adr_o", adr_o, 0);
    check("rst read_en", reg_read_en, 0);
    check("rst response_o", response_o, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    begin_seq(2'd1);
    step();
    check("rst restart strobe", reg_read_en, 1);
    check("rst restart adr", adr_o, 0);
    wait_done("rst restart done");
    check("rst restart response_o", response_o, 16);
    step(2);

`ifdef REG_BUS_SEQ_CHECK_EN
    // Mode 2 with corrupted read-back at address 3.
    corrupt = 1'b1;
    begin_seq(2'd2);
    wait_done("chk done");
    step();
    check("chk mismatch_count", mismatch_count, 1);
    check("chk error_irq", error_interrupt_status_o, 16'h0001);
    corrupt = 1'b0;
    begin_seq(2'd0);
    check("chk cleared count", mismatch_count, 0);
    check("chk cleared irq", error_interrupt_status_o, 16'h0000);
    wait_done("chk clear seq done");
    step(2);
`else
    check("error_irq idle", error_interrupt_status_o, 16'h0000);
`endif

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
